decode_stage: RTL

- Instruction-decode pipeline stage (RV32I) between fetch and execute.
- Drives register-file read addresses combinationally from the incoming instruction.
- Captures the register-file read data, generated immediate and control word into one output register that feeds execute.
- Detects load-use hazards and inserts bubbles; accepts flushes from execute on taken branches and jumps.

---
 rtl/decode_pkg.sv | 59 +++++
 rtl/decode_stage_if.sv | 34 +++
 rtl/decode_stage_imm_gen.sv | 28 ++
 rtl/decode_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared RV32I decode constants, packed control word layout and format lookup
// for the decode stage.
package decode_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Declared MSB first: jump is bit 15, alu_op occupies [3:0].
  typedef struct packed {
    logic       jump;
    logic       branch;
    logic [1:0] wb_sel;
    logic       reg_write;
    logic [2:0] funct3;
    logic       mem_write;
    logic       mem_read;
    logic       src_pc;
    logic       src_imm;
    logic [3:0] alu_op;
  } ctrl_t;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE} fmt_e;

  function automatic fmt_e fmt_of(input logic [6:0] opc);
    case (opc)
      OPC_OP:                       return FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: return FMT_I;
      OPC_STORE:                    return FMT_S;
      OPC_BRANCH:                   return FMT_B;
      OPC_LUI, OPC_AUIPC:           return FMT_U;
      OPC_JAL:                      return FMT_J;
      default:                      return FMT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// slave = the decode stage, master = its environment (fetch + execute).
interface decode_stage_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [XLEN-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_rs1_val;
  logic [XLEN-1:0]   out_rs2_val;
  logic [XLEN-1:0]   out_imm;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [4:0]        out_rd;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
           out_rs1, out_rs2, out_rd, out_ctrl, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
           out_rs1, out_rs2, out_rd, out_ctrl, out_illegal
  );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator; the format is chosen from the
// opcode and the result is sign-extended to XLEN (0 for R-type / illegal).
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]            instr,
  output logic signed [XLEN-1:0] imm
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt_of(instr[6:0]))
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register-file addressing, load-use bubble insertion,
// flush handling and one output register toward execute.
// Optional DECODE_PERF_EN adds stall/flush event counters.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  decode_stage_if.slave   dec,
  output logic [4:0]      rf_a1,
  output logic [4:0]      rf_a2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            flush
`ifdef DECODE_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  function automatic logic [3:0] alu_op_of(input logic [2:0] f3, input logic f7b5,
                                           input logic is_op);
    case (f3)
      3'b000:  return (is_op && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // ---- p0: combinational decode of the incoming instruction ----
  logic [6:0]            opc_p0;
  logic [2:0]            f3_p0;
  fmt_e                  fmt_p0;
  logic                  use1_p0, use2_p0, illegal_p0;
  logic [4:0]            rs1_p0, rs2_p0, rd_p0;
  ctrl_t                 ctrl_p0;
  logic signed [XLEN-1:0] imm_p0;

  assign opc_p0  = dec.in_instr[6:0];
  assign f3_p0   = dec.in_instr[14:12];
  assign fmt_p0  = fmt_of(opc_p0);
  assign use1_p0 = (fmt_p0 == FMT_R) || (fmt_p0 == FMT_I) || (fmt_p0 == FMT_S) || (fmt_p0 == FMT_B);
  assign use2_p0 = (fmt_p0 == FMT_R) || (fmt_p0 == FMT_S) || (fmt_p0 == FMT_B);

  always_comb begin
    ctrl_p0    = '0;
    illegal_p0 = 1'b0;
    case (opc_p0)
      OPC_OP: begin
        ctrl_p0.alu_op = alu_op_of(f3_p0, dec.in_instr[30], 1'b1);
        ctrl_p0.funct3 = f3_p0; ctrl_p0.reg_write = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl_p0.alu_op = alu_op_of(f3_p0, dec.in_instr[30], 1'b0);
        ctrl_p0.src_imm = 1'b1; ctrl_p0.funct3 = f3_p0; ctrl_p0.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_p0.src_imm = 1'b1; ctrl_p0.mem_read = 1'b1; ctrl_p0.funct3 = f3_p0;
        ctrl_p0.reg_write = 1'b1; ctrl_p0.wb_sel = WB_MEM;
      end
      OPC_STORE: begin
        ctrl_p0.src_imm = 1'b1; ctrl_p0.mem_write = 1'b1; ctrl_p0.funct3 = f3_p0;
      end
      OPC_BRANCH: begin
        ctrl_p0.alu_op = ALU_SUB; ctrl_p0.branch = 1'b1; ctrl_p0.funct3 = f3_p0;
      end
      OPC_JAL: begin
        ctrl_p0.src_pc = 1'b1; ctrl_p0.src_imm = 1'b1; ctrl_p0.jump = 1'b1;
        ctrl_p0.reg_write = 1'b1; ctrl_p0.wb_sel = WB_PC4;
      end
      OPC_JALR: begin
        ctrl_p0.src_imm = 1'b1; ctrl_p0.jump = 1'b1; ctrl_p0.funct3 = f3_p0;
        ctrl_p0.reg_write = 1'b1; ctrl_p0.wb_sel = WB_PC4;
      end
      OPC_LUI: begin
        ctrl_p0.alu_op = ALU_PASS_B; ctrl_p0.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl_p0.src_pc = 1'b1; ctrl_p0.reg_write = 1'b1;
      end
      default: illegal_p0 = 1'b1;
    endcase
  end

  // Unused source fields read as x0 so forwarding and hazard compares never hit.
  assign rs1_p0 = use1_p0 ? dec.in_instr[19:15] : 5'd0;
  assign rs2_p0 = use2_p0 ? dec.in_instr[24:20] : 5'd0;
  assign rd_p0  = ctrl_p0.reg_write ? dec.in_instr[11:7] : 5'd0;
  assign rf_a1  = rs1_p0;
  assign rf_a2  = rs2_p0;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (dec.in_instr),
    .imm   (imm_p0)
  );

  // ---- p1: output register toward execute ----
  logic              vld_p1, illegal_p1;
  logic [XLEN-1:0]   pc_p1, rs1_val_p1, rs2_val_p1, imm_p1;
  logic [4:0]        rs1_p1, rs2_p1, rd_p1;
  ctrl_t             ctrl_p1;
  logic              adv, haz;

  assign adv = !vld_p1 || dec.out_ready;
  assign haz = vld_p1 && ctrl_p1.mem_read && (rd_p1 != 5'd0) &&
               ((rs1_p0 == rd_p1) || (rs2_p0 == rd_p1));
  assign dec.in_ready = !rst && (flush || (adv && !haz));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
      pc_p1      <= '0;
      rs1_val_p1 <= '0;
      rs2_val_p1 <= '0;
      imm_p1     <= '0;
      rs1_p1     <= '0;
      rs2_p1     <= '0;
      rd_p1      <= '0;
      ctrl_p1    <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (adv) begin
      if (haz || !dec.in_valid) begin
        vld_p1 <= 1'b0;
      end else begin
        vld_p1     <= 1'b1;
        illegal_p1 <= illegal_p0;
        pc_p1      <= dec.in_pc;
        rs1_val_p1 <= rf_rd1;
        rs2_val_p1 <= rf_rd2;
        imm_p1     <= imm_p0;
        rs1_p1     <= rs1_p0;
        rs2_p1     <= rs2_p0;
        rd_p1      <= rd_p0;
        ctrl_p1    <= ctrl_p0;
      end
    end
  end

  logic [15:0] ctrl_bits_p1;
  assign ctrl_bits_p1    = ctrl_p1;
  assign dec.out_valid   = vld_p1;
  assign dec.out_illegal = illegal_p1;
  assign dec.out_pc      = pc_p1;
  assign dec.out_rs1_val = rs1_val_p1;
  assign dec.out_rs2_val = rs2_val_p1;
  assign dec.out_imm     = imm_p1;
  assign dec.out_rs1     = rs1_p1;
  assign dec.out_rs2     = rs2_p1;
  assign dec.out_rd      = rd_p1;
  assign dec.out_ctrl    = CTRL_W'(ctrl_bits_p1);

`ifdef DECODE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (haz && adv) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush && (vld_p1 || dec.in_valid)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
